timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_defs.sv | 21 ++
 rtl/counter.sv | 49 ++++
 rtl/timer_ctrl.sv | 131 +++++++++++++
 tb/tb_timer_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/timer_defs.sv
// timer_defs: definitions shared by every timer channel.
//   - FSM state encodings (IDLE / RUN)
//   - legal prescaler range and the derived prescaler width
//   - count datapath width
package timer_defs;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned DIV_MIN = 1;
  localparam int unsigned DIV_MAX = 256;
  // Wide enough to hold 0..DIV_MAX-1
  localparam int unsigned PRESC_W = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_e;

endpackage

// File: rtl/counter.sv
// counter: loadable up-counter that wraps to zero at limit-1.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   inc          - advance one step (wraps at limit-1)
//   load         - overwrite with load_val (priority over inc)
//   load_val     - value written when load is high
//   limit        - wrap point; the counter runs 0..limit-1
//   count        - current value
//   wrap         - high in the cycle an inc will wrap to zero
module counter
  import timer_defs::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap = inc && (count_q == (limit - W'(1)));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled one-shot / periodic timer with sticky interrupt.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-low reset
//   start    - arm / re-arm (ignored when period == 0)
//   stop     - halt; wins over a coincident start
//   mode     - 0 one-shot, 1 periodic (sampled with start)
//   period   - expiry interval in counts (sampled with start)
//   irq_ack  - clears a pending irq
//   busy     - high while running
//   count    - current count value
//   irq      - level interrupt, set on expiry, held until acknowledged
//   overrun  - sticky: an expiry hit while irq was still pending
module timer_ctrl
  import timer_defs::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  input  logic             irq_ack,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             irq,
  output logic             overrun
);

  if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_div_range
    $error("timer_ctrl: DIV out of range");
  end

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               mode_q, mode_d;
  logic               irq_q, irq_d;
  logic               overrun_q, overrun_d;

  logic               running;
  logic               start_acc;
  logic               tick;
  logic               expiry;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;

  assign running   = (state_q == RUN);
  // A zero period is never accepted; stop beats a coincident start.
  assign start_acc = start && (period != '0) && !stop;
  // A stop or a restart on this edge suppresses the tick, so no expiry is seen.
  assign tick      = running && !stop && !start_acc && (presc_q == PRESC_LAST);

  // Clear on restart; otherwise hold the current value unless ticking.
  assign cnt_load     = start_acc || !tick;
  assign cnt_load_val = start_acc ? '0 : count;

  counter #(
    .W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (tick),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .limit    (period_q),
    .count    (count),
    .wrap     (expiry)
  );

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    period_d  = period_q;
    mode_d    = mode_q;
    irq_d     = irq_q;
    overrun_d = overrun_q;

    if (start_acc) begin
      state_d   = RUN;
      presc_d   = '0;
      period_d  = period;
      mode_d    = mode;
      overrun_d = 1'b0;
    end else if (running && stop) begin
      state_d = IDLE;
    end else if (running) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
      if (expiry && !mode_q) begin
        state_d = IDLE;
      end
    end

    // Expiry takes priority over a coincident acknowledge.
    if (expiry) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) begin
        overrun_d = 1'b1;
      end
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      period_q  <= '0;
      mode_q    <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy    = running;
  assign irq     = irq_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, mode, irq_ack;
  logic [31:0] period;

  logic        busy1, irq1, ov1;
  logic [31:0] count1;
  logic        busy4, irq4, ov4;
  logic [31:0] count4;

  always #5 clk = ~clk;

  timer_ctrl #(.DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .period(period), .irq_ack(irq_ack), .busy(busy1), .count(count1),
    .irq(irq1), .overrun(ov1)
  );

  timer_ctrl #(.DIV(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .period(period), .irq_ack(irq_ack), .busy(busy4), .count(count4),
    .irq(irq4), .overrun(ov4)
  );

  typedef struct packed {
    logic        d4;
    logic        b;
    logic [31:0] c;
    logic        i;
    logic        o;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  task automatic push(input string tag, input logic d4, input logic b,
                      input logic [31:0] c, input logic i, input logic o);
    exp_t e;
    e.d4 = d4; e.b = b; e.c = c; e.i = i; e.o = o;
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic chk();
    exp_t        e;
    string       tag;
    logic        ob, oi, oo;
    logic [31:0] oc;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed 0 entries expected 1");
      return;
    end
    e   = sb.pop_front();
    tag = tq.pop_front();
    ob  = e.d4 ? busy4  : busy1;
    oc  = e.d4 ? count4 : count1;
    oi  = e.d4 ? irq4   : irq1;
    oo  = e.d4 ? ov4    : ov1;
    n_assert++;
    assert (ob === e.b) else begin
      n_fail++;
      $error("FAIL %s busy observed %0b expected %0b", tag, ob, e.b);
    end
    n_assert++;
    assert (oc === e.c) else begin
      n_fail++;
      $error("FAIL %s count observed %0d expected %0d", tag, oc, e.c);
    end
    n_assert++;
    assert (oi === e.i) else begin
      n_fail++;
      $error("FAIL %s irq observed %0b expected %0b", tag, oi, e.i);
    end
    n_assert++;
    assert (oo === e.o) else begin
      n_fail++;
      $error("FAIL %s overrun observed %0b expected %0b", tag, oo, e.o);
    end
  endtask

  // Drive one cycle of inputs, take the edge, release pulses, compare.
  task automatic step(input logic s, input logic st, input logic m,
                      input logic [31:0] p, input logic a);
    start = s; stop = st; mode = m; period = p; irq_ack = a;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
    chk();
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    period = 32'd0; irq_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("rst1", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0); chk();
    push("rst4", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0); chk();
    reset = 1'b1;

    // One-shot, period 3
    push("a_start", 0, 1, 0, 0, 0); step(1, 0, 0, 3, 0);
    push("a_c1",    0, 1, 1, 0, 0); step(0, 0, 0, 3, 0);
    push("a_c2",    0, 1, 2, 0, 0); step(0, 0, 0, 3, 0);
    push("a_exp",   0, 0, 0, 1, 0); step(0, 0, 0, 3, 0);
    push("a_idle",  0, 0, 0, 1, 0); step(0, 0, 0, 3, 0);
    push("a_ack",   0, 0, 0, 0, 0); step(0, 0, 0, 3, 1);

    // Periodic, period 2, no ack until after overrun
    push("b_start", 0, 1, 0, 0, 0); step(1, 0, 1, 2, 0);
    push("b_c1",    0, 1, 1, 0, 0); step(0, 0, 0, 7, 0);
    push("b_exp1",  0, 1, 0, 1, 0); step(0, 0, 0, 7, 0);
    push("b_c1b",   0, 1, 1, 1, 0); step(0, 0, 0, 7, 0);
    push("b_exp2",  0, 1, 0, 1, 1); step(0, 0, 0, 7, 0);
    push("b_ack",   0, 1, 1, 0, 1); step(0, 0, 0, 7, 1);
    push("b_stop",  0, 0, 1, 0, 1); step(0, 1, 0, 7, 0);
    push("b_hold",  0, 0, 1, 0, 1); step(0, 0, 0, 7, 0);

    // DIV = 4, periodic, period 2, ack coincident with expiry
    reset_pulse();
    push("c_start", 1, 1, 0, 0, 0); step(1, 0, 1, 2, 0);
    for (int k = 0; k < 3; k++) begin
      push("c_pre0", 1, 1, 0, 0, 0); step(0, 0, 0, 2, 0);
    end
    push("c_tick", 1, 1, 1, 0, 0); step(0, 0, 0, 2, 0);
    for (int k = 0; k < 3; k++) begin
      push("c_pre1", 1, 1, 1, 0, 0); step(0, 0, 0, 2, 0);
    end
    push("c_exp_ack", 1, 1, 0, 1, 0); step(0, 0, 0, 2, 1);
    push("c_after",   1, 1, 0, 1, 0); step(0, 0, 0, 2, 0);

    // start+stop together at count 5, then zero-period start
    reset_pulse();
    push("d_start", 0, 1, 0, 0, 0); step(1, 0, 1, 10, 0);
    for (int k = 1; k <= 5; k++) begin
      push("d_run", 0, 1, 32'(k), 0, 0); step(0, 0, 1, 10, 0);
    end
    push("d_ss",    0, 0, 5, 0, 0); step(1, 1, 1, 10, 0);
    push("d_zero",  0, 0, 5, 0, 0); step(1, 0, 1, 0, 0);

    // Restart in RUN cancels a pending expiry; new mode/period take effect
    push("e_start", 0, 1, 0, 0, 0); step(1, 0, 1, 2, 0);
    push("e_c1",    0, 1, 1, 0, 0); step(0, 0, 1, 2, 0);
    push("e_rearm", 0, 1, 0, 0, 0); step(1, 0, 0, 3, 0);
    push("e_c1b",   0, 1, 1, 0, 0); step(0, 0, 1, 9, 0);
    push("e_c2",    0, 1, 2, 0, 0); step(0, 0, 1, 9, 0);
    push("e_exp",   0, 0, 0, 1, 0); step(0, 0, 1, 9, 0);

    // Async reset mid-RUN at count 7; zero-period start ignored in RUN
    reset_pulse();
    push("f_start", 0, 1, 0, 0, 0); step(1, 0, 1, 10, 0);
    for (int k = 1; k <= 5; k++) begin
      push("f_run", 0, 1, 32'(k), 0, 0); step(0, 0, 1, 10, 0);
    end
    push("f_zero_run", 0, 1, 6, 0, 0); step(1, 0, 1, 0, 0);
    push("f_c7",       0, 1, 7, 0, 0); step(0, 0, 1, 4, 0);
    reset = 1'b0;
    #2;
    push("f_async", 0, 0, 0, 0, 0); chk();
    reset = 1'b1;
    push("f_post1", 0, 0, 0, 0, 0); step(0, 0, 1, 10, 0);
    push("f_post2", 0, 0, 0, 0, 0); step(0, 0, 1, 10, 0);

    // period = 1 expires every tick
    push("g_start", 0, 1, 0, 0, 0); step(1, 0, 1, 1, 0);
    push("g_exp1",  0, 1, 0, 1, 0); step(0, 0, 1, 1, 0);
    push("g_exp2",  0, 1, 0, 1, 1); step(0, 0, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
